// File: rtl/flop_arb_pkg.sv
// ============================================================================
// Module   : flop_arb_pkg
// Brief    : Shared types, defaults and helpers for the flop-share arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package flop_arb_pkg;

  localparam int c_def_nreq     = 4;
  localparam int c_def_max_hold = 8;
  localparam int c_max_nreq     = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Valid only for one-hot (or zero) input; OR-reduction avoids a priority chain.
  function automatic logic [3:0] onehot_to_idx(input logic [c_max_nreq-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < c_max_nreq; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker; first set req bit from ptr up.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import flop_arb_pkg::*;
#(
  parameter  int NREQ = c_def_nreq,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] pick,
  output logic [IDW-1:0]  pick_idx,
  output logic            any_req
);

  logic           w_found;
  logic [IDW-1:0] w_cand;

  always_comb begin
    pick    = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = IDW'((int'(ptr) + i) % NREQ);
      if (!w_found && req[w_cand]) begin
        pick[w_cand] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

  assign pick_idx = IDW'(onehot_to_idx(c_max_nreq'(pick)));
  assign any_req  = |req;

endmodule

`default_nettype wire

// File: rtl/flop_share_arbiter.sv
// ============================================================================
// Module   : flop_share_arbiter
// Brief    : Round-robin arbiter sharing one sync-cleared flop among NREQ users.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flop_share_arbiter
  import flop_arb_pkg::*;
#(
  parameter  int NREQ     = c_def_nreq,
  parameter  int MAX_HOLD = c_def_max_hold,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] wdata,
  input  logic            clr_req,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_id,
  output logic            flop_din,
  output logic            flop_clr
);

  localparam int             c_hcw       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [c_hcw-1:0] c_hold_last = (MAX_HOLD > 0) ? c_hcw'(MAX_HOLD - 1) : '0;

  generate
    if (NREQ < 2 || NREQ > c_max_nreq) begin : g_nreq_check
      $error("flop_share_arbiter: NREQ must be within 2..16");
    end
  endgenerate

  state_t           r_state, w_state_next;
  logic [IDW-1:0]   r_ptr, w_ptr_next;
  logic [c_hcw-1:0] r_hold_cnt, w_hold_next;
  logic [NREQ-1:0]  r_gnt, w_gnt_next;
  logic             r_gnt_valid, w_gnt_valid_next;
  logic [IDW-1:0]   r_gnt_id, w_gnt_id_next;
  logic             r_flop_clr;

  logic [IDW-1:0]   w_id_succ, w_pick_ptr, w_pick_idx;
  logic [NREQ-1:0]  w_pick;
  logic             w_any, w_owner_req, w_others, w_hold_expired;
  logic             w_take, w_drop;

  // While granted, search always starts just after the owner, so a
  // preemption or release hands over in round-robin order.
  assign w_id_succ      = (r_gnt_id == IDW'(NREQ - 1)) ? '0 : r_gnt_id + 1'b1;
  assign w_pick_ptr     = (r_state == GRANT) ? w_id_succ : r_ptr;
  assign w_owner_req    = req[r_gnt_id];
  assign w_others       = |(req & ~r_gnt);
  assign w_hold_expired = (MAX_HOLD != 0) && (r_hold_cnt == c_hold_last);

  rr_pick #(
    .NREQ     (NREQ)
  ) u_rr_pick (
    .req      (req),
    .ptr      (w_pick_ptr),
    .pick     (w_pick),
    .pick_idx (w_pick_idx),
    .any_req  (w_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_flop_clr  <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_hold_cnt  <= w_hold_next;
      r_gnt       <= w_gnt_next;
      r_gnt_valid <= w_gnt_valid_next;
      r_gnt_id    <= w_gnt_id_next;
      r_flop_clr  <= clr_req;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_hold_next  = r_hold_cnt;
    w_take       = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_next = GRANT;
          w_hold_next  = '0;
          w_take       = 1'b1;
        end
      end
      GRANT: begin
        if (!w_owner_req) begin
          w_ptr_next  = w_id_succ;
          w_hold_next = '0;
          if (w_any) begin
            w_take = 1'b1;
          end else begin
            w_state_next = IDLE;
            w_drop       = 1'b1;
          end
        end else if (w_hold_expired && w_others) begin
          w_take      = 1'b1;
          w_hold_next = '0;
        end else if (r_hold_cnt != c_hold_last) begin
          w_hold_next = r_hold_cnt + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_gnt_next       = r_gnt;
    w_gnt_valid_next = r_gnt_valid;
    w_gnt_id_next    = r_gnt_id;
    if (w_take) begin
      w_gnt_next       = w_pick;
      w_gnt_valid_next = 1'b1;
      w_gnt_id_next    = w_pick_idx;
    end else if (w_drop) begin
      w_gnt_next       = '0;
      w_gnt_valid_next = 1'b0;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign gnt_id    = r_gnt_id;
  assign flop_clr  = r_flop_clr;
  assign flop_din  = r_gnt_valid & wdata[r_gnt_id];

endmodule

`default_nettype wire

// File: tb/tb_flop_share_arbiter.sv
// ============================================================================
// Module   : tb_flop_share_arbiter
// Brief    : Self-checking bench: vector table, corner sequences, random vs model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flop_share_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;

  logic         clk     = 1'b0;
  logic         reset   = 1'b0;
  logic [N-1:0] req     = '0;
  logic [N-1:0] wdata   = '0;
  logic         clr_req = 1'b0;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_id;
  logic         flop_din;
  logic         flop_clr;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: current owner (-1 = none), last granted id, pointer,
  // and number of cycles the owner has held the grant so far.
  int   m_owner, m_id, m_ptr, m_ten;
  logic m_clr;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] wdata;
    logic         clr;
    logic [N-1:0] gnt;
    logic         valid;
    logic [1:0]   id;
    logic         din;
    logic         fclr;
  } vec_t;

  vec_t tbl[9];

  always #5 clk = ~clk;

  flop_share_arbiter #(
    .NREQ      (N),
    .MAX_HOLD  (MH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .wdata     (wdata),
    .clr_req   (clr_req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .flop_din  (flop_din),
    .flop_clr  (flop_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int first_from(input int s, input logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (s + i) % N;
      if (((r >> k) & 1) != 0) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_id    = 0;
    m_ptr   = 0;
    m_ten   = 0;
    m_clr   = 1'b1;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic c);
    int           nw;
    logic [N-1:0] own_mask;
    m_clr = c;
    if (m_owner < 0) begin
      if (r != 0) begin
        m_owner = first_from(m_ptr, r);
        m_id    = m_owner;
        m_ten   = 1;
      end
    end else begin
      own_mask = N'(1) << m_owner;
      if ((r & own_mask) == 0) begin
        m_ptr = (m_owner + 1) % N;
        nw    = first_from(m_ptr, r);
        if (nw >= 0) begin
          m_owner = nw;
          m_id    = nw;
          m_ten   = 1;
        end else begin
          m_owner = -1;
        end
      end else if (MH != 0 && m_ten >= MH && (r & ~own_mask) != 0) begin
        nw      = first_from(m_owner + 1, r);
        m_owner = nw;
        m_id    = nw;
        m_ten   = 1;
      end else begin
        m_ten++;
      end
    end
  endtask

  task automatic apply(input logic [N-1:0] r, input logic [N-1:0] w, input logic c);
    req     = r;
    wdata   = w;
    clr_req = c;
    @(posedge clk);
    model_edge(r, c);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg;
    logic         ed;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    ed = (m_owner >= 0) ? wdata[m_id] : 1'b0;
    chk({tag, "_gnt"},   32'(gnt),       32'(eg));
    chk({tag, "_valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
    chk({tag, "_id"},    32'(gnt_id),    32'(m_id));
    chk({tag, "_din"},   32'(flop_din),  32'(ed));
    chk({tag, "_clr"},   32'(flop_clr),  32'(m_clr));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    int           w;

    //         req      wdata    clr   gnt      v     id     din   fclr
    tbl[0] = '{4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0};
    tbl[1] = '{4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0};
    tbl[2] = '{4'b0000, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0};
    tbl[3] = '{4'b0011, 4'b0010, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[4] = '{4'b0011, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0};
    tbl[5] = '{4'b0010, 4'b0001, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0};
    tbl[6] = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b1};
    tbl[7] = '{4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0};
    tbl[8] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0};

    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("rst_gnt",   32'(gnt),       32'(0));
      chk("rst_valid", 32'(gnt_valid), 32'(0));
      chk("rst_din",   32'(flop_din),  32'(0));
      chk("rst_clr",   32'(flop_clr),  32'(1));
    end
    reset = 1'b1;
    apply('0, '0, 1'b0);
    chk("idle_clr", 32'(flop_clr),  32'(0));
    chk("idle_gnt", 32'(gnt),       32'(0));

    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].req, tbl[i].wdata, tbl[i].clr);
      chk($sformatf("tbl%0d_gnt", i),   32'(gnt),       32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_valid", i), 32'(gnt_valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_id", i),    32'(gnt_id),    32'(tbl[i].id));
      chk($sformatf("tbl%0d_din", i),   32'(flop_din),  32'(tbl[i].din));
      chk($sformatf("tbl%0d_fclr", i),  32'(flop_clr),  32'(tbl[i].fclr));
    end

    // Round robin, every winner drops after two cycles: 0,1,2,3,0 back to back.
    do_reset();
    apply(4'b1111, '0, 1'b0);
    chk("rr_first", 32'(gnt), 32'(4'b0001));
    for (int k = 0; k < 4; k++) begin
      apply(4'b1111, '0, 1'b0);
      chk($sformatf("rr%0d_hold", k), 32'(gnt), 32'(4'b0001 << k));
      r = 4'b1111 & ~(4'b0001 << k);
      apply(r, '0, 1'b0);
      w = (k + 1) % N;
      chk($sformatf("rr%0d_next", k),  32'(gnt),       32'(4'b0001 << w));
      chk($sformatf("rr%0d_valid", k), 32'(gnt_valid), 32'(1));
    end
    apply(4'b1111, '0, 1'b0);
    apply('0, '0, 1'b0);
    chk("rr_idle", 32'(gnt_valid), 32'(0));

    // Preemption: owner 0 loses the grant exactly MH cycles after it started.
    apply(4'b0001, '0, 1'b0);
    chk("pre_start", 32'(gnt), 32'(4'b0001));
    for (int c = 1; c <= MH; c++) begin
      apply((c >= 2) ? 4'b1001 : 4'b0001, '0, 1'b0);
      chk($sformatf("pre_c%0d", c), 32'(gnt), 32'((c < MH) ? 4'b0001 : 4'b1000));
    end
    chk("pre_id", 32'(gnt_id), 32'(3));
    apply('0, '0, 1'b0);
    for (int c = 0; c < 12; c++) begin
      apply(4'b0001, '0, 1'b0);
      chk($sformatf("keep_c%0d", c), 32'(gnt), 32'(4'b0001));
    end
    apply('0, '0, 1'b0);

    // Asynchronous reset between edges while requester 1 holds the grant.
    apply(4'b0010, '0, 1'b0);
    chk("ar_pre", 32'(gnt), 32'(4'b0010));
    #2;
    reset = 1'b0;
    #1;
    chk("ar_gnt",   32'(gnt),       32'(0));
    chk("ar_valid", 32'(gnt_valid), 32'(0));
    chk("ar_clr",   32'(flop_clr),  32'(1));
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    apply(4'b0011, '0, 1'b0);
    chk("ar_regrant", 32'(gnt),    32'(4'b0001));
    chk("ar_id",      32'(gnt_id), 32'(0));

    // Randomised traffic against the reference model.
    r = '0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++) begin
        if (r[b]) r[b] = ($urandom_range(0, 7) != 0);
        else      r[b] = ($urandom_range(0, 3) == 0);
      end
      apply(r, N'($urandom), ($urandom_range(0, 7) == 0));
      check_model("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
